// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave bridge.
// Reset levels here describe an idle, deselected bus.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = 3;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CSN_IDLE  = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer with async reset.
// Reset value lets each input settle to its idle level.
module sync_ff #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  // shift the async input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: oversampled RX byte assembly
// and TX serialization of the decoder's reply byte.
module spi_bridge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOAD_DELAY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_en,
  output logic                  byte_sync,
  output logic [SPI_BYTE_W-1:0] data_in,
  input  logic [SPI_BYTE_W-1:0] data_out,
  output logic                  frame_err
);

  localparam int LDW = $clog2(LOAD_DELAY + 1);
  localparam int FLW = SYNC_STAGES + 1;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES),
    .RST_VAL(SCLK_IDLE)
  ) u_sync_sclk (
    .clk(clk),
    .rst(rst),
    .d  (sclk),
    .q  (sclk_s)
  );

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES),
    .RST_VAL(CSN_IDLE)
  ) u_sync_cs (
    .clk(clk),
    .rst(rst),
    .d  (cs_n),
    .q  (cs_s)
  );

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES),
    .RST_VAL(MOSI_IDLE)
  ) u_sync_mosi (
    .clk(clk),
    .rst(rst),
    .d  (mosi),
    .q  (mosi_s)
  );

  // history flops for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= SCLK_IDLE;
      cs_q   <= CSN_IDLE;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  // The synchronizer resets to "deselected", so a chip select
  // already low at reset release would look like a fresh fall.
  // Only accept cs_fall once a real high level has been seen.
  logic [FLW-1:0] flush_q;
  logic           armed_q;

  // flush the sync chain, then arm on a genuine idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      flush_q <= {flush_q[FLW-2:0], 1'b1};
      if (flush_q[FLW-1] && cs_s)
        armed_q <= 1'b1;
    end
  end

  logic rise, fall, cs_fall, cs_rise;

  assign rise    =  sclk_s & ~sclk_q;
  assign fall    = ~sclk_s &  sclk_q;
  assign cs_fall = ~cs_s & cs_q & armed_q;
  assign cs_rise =  cs_s & ~cs_q;

  spi_state_e                state_q;
  logic [SPI_CNT_W-1:0]      bit_cnt_q;
  logic [SPI_BYTE_W-2:0]     rx_q;
  logic [SPI_BYTE_W-1:0]     tx_q;
  logic [SPI_BYTE_W-1:0]     data_in_q;
  logic                      byte_sync_q;
  logic                      frame_err_q;
  logic                      miso_en_q;
  logic [LDW-1:0]            ld_cnt_q;
  logic                      load_now;

  assign load_now = (ld_cnt_q == LDW'(1));

  // frame FSM with bit counter, shifters and reply-load timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      data_in_q   <= '0;
      byte_sync_q <= 1'b0;
      frame_err_q <= 1'b0;
      miso_en_q   <= 1'b0;
      ld_cnt_q    <= '0;
    end else begin
      byte_sync_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (ld_cnt_q != '0)
        ld_cnt_q <= ld_cnt_q - LDW'(1);
      if (load_now)
        tx_q <= data_out;
      if (byte_sync_q)
        ld_cnt_q <= LDW'(LOAD_DELAY);
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_en_q <= 1'b1;
            ld_cnt_q  <= '0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            miso_en_q <= 1'b0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            ld_cnt_q  <= '0;
            if (bit_cnt_q != '0)
              frame_err_q <= 1'b1;
          end else if (rise) begin
            rx_q      <= {rx_q[SPI_BYTE_W-3:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
            if (bit_cnt_q == '1) begin
              data_in_q   <= {rx_q, mosi_s};
              byte_sync_q <= 1'b1;
            end
          end else if (fall && bit_cnt_q != '0 && !load_now) begin
            tx_q <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso      = tx_q[SPI_BYTE_W-1] & miso_en_q;
  assign miso_en   = miso_en_q;
  assign byte_sync = byte_sync_q;
  assign data_in   = data_in_q;
  assign frame_err = frame_err_q;

endmodule
